// File: rtl/spmv_pkg.sv
// Shared types and helpers for the SpMV reduction node.
// Holds the route enum, statistics width and the value extender.
package spmv_pkg;

    typedef enum logic {
        ROUTE_A = 1'b0,
        ROUTE_B = 1'b1
    } route_e;

    localparam int SPMV_STAT_W = 16;
    localparam int SPMV_MAX_W  = 64;

    // Sign- or zero-extend the low `width` bits of value to full width.
    function automatic logic [SPMV_MAX_W-1:0] spmv_ext(
        input logic [SPMV_MAX_W-1:0] value,
        input int                    width,
        input logic                  is_signed
    );
        logic [SPMV_MAX_W-1:0] r;
        logic                  msb;
        msb = is_signed & value[width-1];
        for (int i = 0; i < SPMV_MAX_W; i++) begin
            r[i] = (i < width) ? value[i] : msb;
        end
        return r;
    endfunction

endpackage

// File: rtl/spmv_node_fifo.sv
// Output FIFO with two ordered push ports and one pop port.
// Push a lands before push b; a lone push b takes the first free slot.
module spmv_node_fifo
    import spmv_pkg::*;
#(
    parameter int DW    = 22,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push_a,
    input  logic [DW-1:0] i_data_a,
    input  logic          i_push_b,
    input  logic [DW-1:0] i_data_b,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wr_b;
    logic          w_pop;

    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign w_pop   = i_pop & o_valid;
    assign w_wr_b  = i_push_a ? (r_wptr + AW'(1)) : r_wptr;
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;

    // Storage write; both pushes may land in one cycle.
    always_ff @(posedge clk) begin
        if (i_push_a) r_mem[r_wptr] <= i_data_a;
        if (i_push_b) r_mem[w_wr_b] <= i_data_b;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_push_a) + AW'(i_push_b);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(i_push_a) + CW'(i_push_b)
                     - CW'(w_pop);
        end
    end

endmodule

// File: rtl/spmv_reduce_node.sv
// Two-lane SpMV reduction node: merges equal ids, steers by one id bit.
// Optional statistics counters are enabled by SPMV_NODE_STATS_EN.
module spmv_reduce_node
    import spmv_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = IN_WIDTH + 1,
    parameter int ID_WIDTH   = 13,
    parameter int LOCATION   = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int SIGNED     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ID_WIDTH-1:0]  in_a_id,
    input  logic [ID_WIDTH-1:0]  in_b_id,
    input  logic [IN_WIDTH-1:0]  in_a_val,
    input  logic [IN_WIDTH-1:0]  in_b_val,
    input  logic                 in_a_valid,
    input  logic                 in_b_valid,
    output logic                 in_ready,
    output logic [ID_WIDTH-1:0]  out_a_id,
    output logic [ID_WIDTH-1:0]  out_b_id,
    output logic [OUT_WIDTH-1:0] out_a_val,
    output logic [OUT_WIDTH-1:0] out_b_val,
    output logic                 out_a_valid,
    output logic                 out_b_valid,
    input  logic                 out_a_ready,
    input  logic                 out_b_ready
`ifdef SPMV_NODE_STATS_EN
    ,
    output logic [SPMV_STAT_W-1:0] merge_count,
    output logic [SPMV_STAT_W-1:0] collision_count
`endif
);

    localparam int DW = ID_WIDTH + OUT_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (OUT_WIDTH < IN_WIDTH + 1) begin : g_chk_w
        $error("OUT_WIDTH must be at least IN_WIDTH+1");
    end
    if (OUT_WIDTH > SPMV_MAX_W) begin : g_chk_max
        $error("OUT_WIDTH exceeds SPMV_MAX_W");
    end
    if (LOCATION >= ID_WIDTH) begin : g_chk_loc
        $error("LOCATION must be below ID_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic [SPMV_MAX_W-1:0] w_ext_a_full;
    logic [SPMV_MAX_W-1:0] w_ext_b_full;
    logic [OUT_WIDTH-1:0]  w_ext_a;
    logic [OUT_WIDTH-1:0]  w_ext_b;
    logic [OUT_WIDTH-1:0]  w_sum;
    logic                  w_unused_ext;
    route_e                w_route_a;
    route_e                w_route_b;
    logic                  w_acc;
    logic                  w_both;
    logic                  w_merge;
    logic                  w_merge_beat;
    logic                  w_collision_beat;
    logic [DW-1:0]         w_data0;
    logic [DW-1:0]         w_data1;
    logic                  w_a_push0;
    logic                  w_a_push1;
    logic                  w_b_push0;
    logic                  w_b_push1;
    logic [DW-1:0]         w_head_a;
    logic [DW-1:0]         w_head_b;
    logic [CW-1:0]         w_cnt_a;
    logic [CW-1:0]         w_cnt_b;
    logic                  r_init;

    assign w_ext_a_full = spmv_ext(SPMV_MAX_W'(in_a_val), IN_WIDTH,
                                   SIGNED != 0);
    assign w_ext_b_full = spmv_ext(SPMV_MAX_W'(in_b_val), IN_WIDTH,
                                   SIGNED != 0);
    assign w_ext_a      = w_ext_a_full[OUT_WIDTH-1:0];
    assign w_ext_b      = w_ext_b_full[OUT_WIDTH-1:0];
    assign w_unused_ext = ^{w_ext_a_full, w_ext_b_full};
    assign w_sum        = w_ext_a + w_ext_b;

    assign w_route_a = route_e'(in_a_id[LOCATION]);
    assign w_route_b = route_e'(in_b_id[LOCATION]);
    assign w_acc     = (in_a_valid | in_b_valid) & in_ready;
    assign w_both    = in_a_valid & in_b_valid;
    assign w_merge   = w_both & (in_a_id == in_b_id);

    assign w_merge_beat     = w_acc & w_merge;
    assign w_collision_beat = w_acc & w_both & ~w_merge
                            & (w_route_a == w_route_b);

    assign w_data0 = w_merge ? {in_a_id, w_sum} : {in_a_id, w_ext_a};
    assign w_data1 = {in_b_id, w_ext_b};

    // Steer lanes into FIFO slots; slot 0 always precedes slot 1.
    always_comb begin
        w_a_push0 = 1'b0;
        w_a_push1 = 1'b0;
        w_b_push0 = 1'b0;
        w_b_push1 = 1'b0;
        if (w_acc) begin
            unique case (1'b1)
                w_merge: begin
                    w_a_push0 = (w_route_a == ROUTE_A);
                    w_b_push0 = (w_route_a == ROUTE_B);
                end
                default: begin
                    w_a_push0 = in_a_valid & (w_route_a == ROUTE_A);
                    w_b_push0 = in_a_valid & (w_route_a == ROUTE_B);
                    w_a_push1 = in_b_valid & (w_route_b == ROUTE_A);
                    w_b_push1 = in_b_valid & (w_route_b == ROUTE_B);
                end
            endcase
        end
    end

    spmv_node_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push_a (w_a_push0),
        .i_data_a (w_data0),
        .i_push_b (w_a_push1),
        .i_data_b (w_data1),
        .i_pop    (out_a_ready),
        .o_data   (w_head_a),
        .o_valid  (out_a_valid),
        .o_count  (w_cnt_a)
    );

    spmv_node_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push_a (w_b_push0),
        .i_data_a (w_data0),
        .i_push_b (w_b_push1),
        .i_data_b (w_data1),
        .i_pop    (out_b_ready),
        .o_data   (w_head_b),
        .o_valid  (out_b_valid),
        .o_count  (w_cnt_b)
    );

    assign out_a_id  = w_head_a[DW-1:OUT_WIDTH];
    assign out_a_val = w_head_a[OUT_WIDTH-1:0];
    assign out_b_id  = w_head_b[DW-1:OUT_WIDTH];
    assign out_b_val = w_head_b[OUT_WIDTH-1:0];

    // Hold off acceptance until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_init <= 1'b0;
        else        r_init <= 1'b1;
    end

    // Leave room for a dual push in either FIFO.
    assign in_ready = r_init
                    & (w_cnt_a <= CW'(FIFO_DEPTH - 2))
                    & (w_cnt_b <= CW'(FIFO_DEPTH - 2));

`ifdef SPMV_NODE_STATS_EN
    logic [SPMV_STAT_W-1:0] r_merge_cnt;
    logic [SPMV_STAT_W-1:0] r_coll_cnt;

    // Saturating merge and collision counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_merge_cnt <= '0;
            r_coll_cnt  <= '0;
        end else begin
            if (w_merge_beat && r_merge_cnt != '1)
                r_merge_cnt <= r_merge_cnt + 1'b1;
            if (w_collision_beat && r_coll_cnt != '1)
                r_coll_cnt <= r_coll_cnt + 1'b1;
        end
    end

    assign merge_count     = r_merge_cnt;
    assign collision_count = r_coll_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_merge_beat | w_collision_beat;
`endif

endmodule

// File: tb/tb_spmv_reduce_node.sv
// Randomized and directed bench for spmv_reduce_node.
// Reference model: two entry queues plus counters.
module tb_spmv_reduce_node;

    typedef logic [21:0] ent_t;

    logic        clk;
    logic        rst_n;
    logic [12:0] in_a_id, in_b_id;
    logic [7:0]  in_a_val, in_b_val;
    logic        in_a_valid, in_b_valid;
    logic        in_ready;
    logic [12:0] out_a_id, out_b_id;
    logic [8:0]  out_a_val, out_b_val;
    logic        out_a_valid, out_b_valid;
    logic        out_a_ready, out_b_ready;
`ifdef SPMV_NODE_STATS_EN
    logic [15:0] merge_count, collision_count;
`endif

    int   checks = 0;
    int   errors = 0;
    ent_t qa[$];
    ent_t qb[$];
    bit   m_init;
    int   m_merges;
    int   m_colls;

    spmv_reduce_node #(
        .IN_WIDTH   (8),
        .OUT_WIDTH  (9),
        .ID_WIDTH   (13),
        .LOCATION   (0),
        .FIFO_DEPTH (4),
        .SIGNED     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_a_id     (in_a_id),
        .in_b_id     (in_b_id),
        .in_a_val    (in_a_val),
        .in_b_val    (in_b_val),
        .in_a_valid  (in_a_valid),
        .in_b_valid  (in_b_valid),
        .in_ready    (in_ready),
        .out_a_id    (out_a_id),
        .out_b_id    (out_b_id),
        .out_a_val   (out_a_val),
        .out_b_val   (out_b_val),
        .out_a_valid (out_a_valid),
        .out_b_valid (out_b_valid),
        .out_a_ready (out_a_ready),
        .out_b_ready (out_b_ready)
`ifdef SPMV_NODE_STATS_EN
        ,
        .merge_count     (merge_count),
        .collision_count (collision_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ext(input logic [7:0] v);
        return {v[7], v};
    endfunction

    function automatic bit m_ready();
        return m_init && qa.size() <= 2 && qb.size() <= 2;
    endfunction

    function automatic void m_push(input logic [12:0] id,
                                   input logic [8:0] v);
        if (id[0]) qb.push_back({id, v});
        else       qa.push_back({id, v});
    endfunction

    function automatic void m_clear();
        qa.delete();
        qb.delete();
        m_init   = 0;
        m_merges = 0;
        m_colls  = 0;
    endfunction

    // Advance one clock and apply the model's view of that edge.
    task automatic tick();
        bit acc, pa, pb;
        acc = (in_a_valid || in_b_valid) && m_ready();
        pa  = qa.size() > 0 && out_a_ready;
        pb  = qb.size() > 0 && out_b_ready;
        @(posedge clk);
        #1;
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (acc) begin
            if (in_a_valid && in_b_valid && in_a_id == in_b_id) begin
                m_push(in_a_id, ext(in_a_val) + ext(in_b_val));
                if (m_merges < 65535) m_merges++;
            end else begin
                if (in_a_valid) m_push(in_a_id, ext(in_a_val));
                if (in_b_valid) m_push(in_b_id, ext(in_b_val));
                if (in_a_valid && in_b_valid &&
                    in_a_id[0] == in_b_id[0] && m_colls < 65535)
                    m_colls++;
            end
        end
        if (rst_n) m_init = 1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_a_valid = 0;
        in_b_valid = 0;
        in_a_id = 0; in_b_id = 0;
        in_a_val = 0; in_b_val = 0;
    endtask

    task automatic drain();
        idle_inputs();
        out_a_ready = 1;
        out_b_ready = 1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        out_a_ready = 1;
        out_b_ready = 1;
        rst_n = 0;
        m_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({out_a_valid, out_b_valid, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000",
                     {out_a_valid, out_b_valid, in_ready});
        end
        checks++;
        if ({out_a_id, out_a_val, out_b_id, out_b_val} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0",
                     {out_a_id, out_a_val, out_b_id, out_b_val});
        end
`ifdef SPMV_NODE_STATS_EN
        checks++;
        if ({merge_count, collision_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0",
                     {merge_count, collision_count});
        end
`endif
        rst_n = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge got %b want 1", in_ready);
        end
    endtask

    task automatic test_merge();
        in_a_id = 5; in_a_val = 100; in_a_valid = 1;
        in_b_id = 5; in_b_val = 100; in_b_valid = 1;
        tick();
        idle_inputs();
        checks++;
        if ({out_b_valid, out_b_id, out_b_val} !== {1'b1, 13'd5, 9'd200}
            || out_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL merge got b=%b/%0d/%0d a_v=%b want 1/5/200 0",
                     out_b_valid, out_b_id, out_b_val, out_a_valid);
        end
`ifdef SPMV_NODE_STATS_EN
        checks++;
        if (merge_count !== 16'd1) begin
            errors++;
            $display("FAIL merge_count got %0d want 1", merge_count);
        end
`endif
        drain();
    endtask

    task automatic test_signed_merge();
        in_a_id = 3; in_a_val = 8'h80; in_a_valid = 1;
        in_b_id = 3; in_b_val = 8'hFF; in_b_valid = 1;
        tick();
        idle_inputs();
        checks++;
        if ({out_b_valid, out_b_id, out_b_val} !==
            {1'b1, 13'd3, 9'h17F}) begin
            errors++;
            $display("FAIL signed_merge got %b/%0d/%h want 1/3/17f",
                     out_b_valid, out_b_id, out_b_val);
        end
        drain();
    endtask

    task automatic test_split();
        in_a_id = 2; in_a_val = 3; in_a_valid = 1;
        in_b_id = 7; in_b_val = 4; in_b_valid = 1;
        tick();
        idle_inputs();
        checks++;
        if ({out_a_valid, out_a_id, out_a_val,
             out_b_valid, out_b_id, out_b_val} !==
            {1'b1, 13'd2, 9'd3, 1'b1, 13'd7, 9'd4}) begin
            errors++;
            $display("FAIL split got a=%b/%0d/%0d b=%b/%0d/%0d",
                     out_a_valid, out_a_id, out_a_val,
                     out_b_valid, out_b_id, out_b_val);
        end
        drain();
    endtask

    task automatic test_collision();
        logic [12:0] exp_id [4];
        logic [8:0]  exp_v  [4];
        exp_id = '{13'd4, 13'd6, 13'd4, 13'd6};
        exp_v  = '{9'd1, 9'd2, 9'd1, 9'd2};
        out_a_ready = 0;
        for (int k = 0; k < 2; k++) begin
            in_a_id = 4; in_a_val = 1; in_a_valid = 1;
            in_b_id = 6; in_b_val = 2; in_b_valid = 1;
            tick();
        end
        idle_inputs();
        checks++;
        if (in_ready !== 1'b0 || qa.size() != 4) begin
            errors++;
            $display("FAIL coll_full ready got %b want 0 (model occ %0d)",
                     in_ready, qa.size());
        end
`ifdef SPMV_NODE_STATS_EN
        checks++;
        if (collision_count !== 16'd2) begin
            errors++;
            $display("FAIL coll_count got %0d want 2", collision_count);
        end
`endif
        out_a_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_a_valid, out_a_id, out_a_val} !==
                {1'b1, exp_id[i], exp_v[i]}) begin
                errors++;
                $display("FAIL coll_pop%0d got %b/%0d/%0d want 1/%0d/%0d",
                         i, out_a_valid, out_a_id, out_a_val,
                         exp_id[i], exp_v[i]);
            end
            checks++;
            if (in_ready !== (i >= 2)) begin
                errors++;
                $display("FAIL coll_ready%0d got %b want %b",
                         i, in_ready, (i >= 2));
            end
            tick();
        end
        checks++;
        if (out_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL coll_empty got %b want 0", out_a_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (out_a_valid !== (qa.size() > 0) ||
                (qa.size() > 0 && {out_a_id, out_a_val} !== qa[0])) begin
                errors++;
                $display("FAIL rand_a c%0d got %b/%h want %0d/%h",
                         c, out_a_valid, {out_a_id, out_a_val},
                         qa.size(), qa.size() > 0 ? qa[0] : 22'h0);
            end
            checks++;
            if (out_b_valid !== (qb.size() > 0) ||
                (qb.size() > 0 && {out_b_id, out_b_val} !== qb[0])) begin
                errors++;
                $display("FAIL rand_b c%0d got %b/%h want %0d/%h",
                         c, out_b_valid, {out_b_id, out_b_val},
                         qb.size(), qb.size() > 0 ? qb[0] : 22'h0);
            end
            checks++;
            if (in_ready !== m_ready()) begin
                errors++;
                $display("FAIL rand_ready c%0d got %b want %b",
                         c, in_ready, m_ready());
            end
            in_a_valid  = 1'($urandom_range(0, 3) != 0);
            in_b_valid  = 1'($urandom_range(0, 3) != 0);
            in_a_id     = 13'($urandom_range(0, 3));
            in_b_id     = 13'($urandom_range(0, 3));
            in_a_val    = 8'($urandom);
            in_b_val    = 8'($urandom);
            out_a_ready = 1'($urandom_range(0, 2) != 0);
            out_b_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
`ifdef SPMV_NODE_STATS_EN
        checks++;
        if (merge_count !== 16'(m_merges) ||
            collision_count !== 16'(m_colls)) begin
            errors++;
            $display("FAIL rand_stats got %0d/%0d want %0d/%0d",
                     merge_count, collision_count, m_merges, m_colls);
        end
`endif
        drain();
    endtask

    task automatic test_reset_midrun();
        out_a_ready = 0;
        in_a_id = 4; in_a_val = 1; in_a_valid = 1;
        in_b_id = 6; in_b_val = 2; in_b_valid = 1;
        tick();
        in_b_valid = 0;
        in_a_id = 8; in_a_val = 3;
        tick();
        idle_inputs();
        checks++;
        if (out_a_valid !== 1'b1 || qa.size() != 3) begin
            errors++;
            $display("FAIL mid_fill got %b want 1 (model occ %0d)",
                     out_a_valid, qa.size());
        end
        rst_n = 0;
        m_clear();
        #1;
        checks++;
        if ({out_a_valid, out_b_valid, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset got %b want 000",
                     {out_a_valid, out_b_valid, in_ready});
        end
        @(negedge clk);
        rst_n = 1;
        out_a_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_a_valid !== 1'b0 || out_a_id !== 13'd0) begin
                errors++;
                $display("FAIL mid_stale%0d got %b/%0d want 0/0",
                         i, out_a_valid, out_a_id);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready got %b want 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_merge();
        test_signed_merge();
        test_split();
        test_collision();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
